// File: rtl/fifo_byte_unpacker.sv
// Drains one FIFO word at a time and serialises it as an optional sync byte plus
// DATA_W/8 data bytes, MSB first, over a valid/ready byte handshake.
module fifo_byte_unpacker #(
    parameter int          DATA_W     = 24,
    parameter int          RD_LATENCY = 1,
    parameter int          HEADER_EN  = 1,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [15:0] WORDS_RST  = 16'h0000
) (
    input  logic              clk_12mhz,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rden,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    localparam int         NB       = DATA_W / 8 + HEADER_EN;
    localparam logic [2:0] LAST_IDX = 3'(NB - 1);
    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY);

    logic [1:0]        r_state;
    logic [1:0]        r_lat;
    logic [2:0]        r_byte_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_rden;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic [15:0]       r_words;

    logic              w_accept;
    logic              w_last;

    assign w_accept = r_tx_valid && tx_ready;
    assign w_last   = (r_byte_idx == LAST_IDX);

    always_ff @(posedge clk_12mhz or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_lat      <= 2'd0;
            r_byte_idx <= 3'd0;
            r_shift    <= '0;
            r_rden     <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_words    <= WORDS_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        r_state <= ST_POP;
                        r_rden  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_POP: begin
                    r_rden  <= 1'b0;
                    r_lat   <= LAT_LOAD;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == 2'd1) begin
                        // The shift register always holds the bytes still to be sent after tx_data.
                        if (HEADER_EN != 0) begin
                            r_tx_data <= SYNC_BYTE;
                            r_shift   <= fifo_q;
                        end else begin
                            r_tx_data <= fifo_q[DATA_W-1 -: 8];
                            r_shift   <= fifo_q << 8;
                        end
                        r_byte_idx <= 3'd0;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_tx_valid <= 1'b0;
                            r_words    <= r_words + 16'd1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx_data  <= r_shift[DATA_W-1 -: 8];
                            r_shift    <= r_shift << 8;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rden     <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rden  = r_rden;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign busy       = r_busy;
    assign words_sent = r_words;

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Directed bench: default instance (header, latency 1) plus a header-less,
// latency-2 instance whose word counter starts at FFFF to exercise the wrap.
module tb_fifo_byte_unpacker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic        a_rst_n = 1'b0, a_enable = 1'b0, a_empty = 1'b1, a_tx_ready = 1'b0;
    logic        a_rden, a_tx_valid, a_busy;
    logic [23:0] a_q = '0;
    logic [7:0]  a_tx_data;
    logic [15:0] a_words;
    logic [23:0] a_fifo[$];
    logic [7:0]  a_bytes[$];
    int          a_rden_cnt = 0, a_bad_rd = 0;

    // Instance B: no header, RD_LATENCY=2, counter preset FFFF
    logic        b_rst_n = 1'b0, b_enable = 1'b0, b_empty = 1'b1, b_tx_ready = 1'b0;
    logic        b_rden, b_tx_valid, b_busy;
    logic [23:0] b_q1 = '0, b_q2 = '0;
    logic [7:0]  b_tx_data;
    logic [15:0] b_words;
    logic [23:0] b_fifo[$];
    logic [7:0]  b_bytes[$];
    int          b_rden_cnt = 0, b_bad_rd = 0;

    fifo_byte_unpacker dut_a (
        .clk_12mhz (clk),
        .reset     (a_rst_n),
        .enable    (a_enable),
        .fifo_empty(a_empty),
        .fifo_q    (a_q),
        .fifo_rden (a_rden),
        .tx_data   (a_tx_data),
        .tx_valid  (a_tx_valid),
        .tx_ready  (a_tx_ready),
        .busy      (a_busy),
        .words_sent(a_words)
    );

    fifo_byte_unpacker #(
        .DATA_W    (24),
        .RD_LATENCY(2),
        .HEADER_EN (0),
        .SYNC_BYTE (8'hA5),
        .WORDS_RST (16'hFFFF)
    ) dut_b (
        .clk_12mhz (clk),
        .reset     (b_rst_n),
        .enable    (b_enable),
        .fifo_empty(b_empty),
        .fifo_q    (b_q2),
        .fifo_rden (b_rden),
        .tx_data   (b_tx_data),
        .tx_valid  (b_tx_valid),
        .tx_ready  (b_tx_ready),
        .busy      (b_busy),
        .words_sent(b_words)
    );

    // FIFO models with lagging Empty flag, plus accepted-byte monitors
    always @(posedge clk) begin
        if (a_tx_valid && a_tx_ready) a_bytes.push_back(a_tx_data);
        if (a_rden) begin
            a_rden_cnt++;
            if (a_fifo.size() == 0) a_bad_rd++;
            else a_q <= a_fifo.pop_front();
        end
        a_empty <= (a_fifo.size() == 0);
    end

    always @(posedge clk) begin
        if (b_tx_valid && b_tx_ready) b_bytes.push_back(b_tx_data);
        b_q2 <= b_q1;
        if (b_rden) begin
            b_rden_cnt++;
            if (b_fifo.size() == 0) b_bad_rd++;
            else b_q1 <= b_fifo.pop_front();
        end
        b_empty <= (b_fifo.size() == 0);
    end

    task automatic test_reset();
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b expected 0", a_rden); end
        checks++; if (a_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", a_tx_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", a_busy); end
        checks++; if (a_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", a_tx_data); end
        checks++; if (a_words !== 16'h0000) begin errors++; $display("FAIL reset_words got %h expected 0000", a_words); end
        checks++; if (b_words !== 16'hFFFF) begin errors++; $display("FAIL reset_b_words got %h expected ffff", b_words); end
    endtask

    task automatic test_empty();
        int viol = 0;
        a_enable   = 1'b1;
        a_tx_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_rden !== 1'b0 || a_tx_valid !== 1'b0 || a_busy !== 1'b0) viol++;
        end
        a_enable = 1'b0;
        checks++; if (viol !== 0) begin errors++; $display("FAIL empty_activity got %0d active cycles expected 0", viol); end
        checks++; if (a_words !== 16'h0000) begin errors++; $display("FAIL empty_words got %h expected 0000", a_words); end
        checks++; if (a_rden_cnt !== 0) begin errors++; $display("FAIL empty_rden_cnt got %0d expected 0", a_rden_cnt); end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b[4];
        logic [7:0] got;
        int t_rden = -1, t_valid = -1, t_first_acc = -1, t_last_acc = -1, rc0;
        exp_b = '{8'hA5, 8'h12, 8'h34, 8'h56};
        @(negedge clk);
        a_bytes.delete();
        rc0 = a_rden_cnt;
        a_fifo.push_back(24'h123456);
        a_tx_ready = 1'b1;
        a_enable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_rden && t_rden < 0) t_rden = i;
            if (a_tx_valid && t_valid < 0) t_valid = i;
            if (a_bytes.size() == 1 && t_first_acc < 0) t_first_acc = i;
            if (a_bytes.size() == 4 && t_last_acc < 0) t_last_acc = i;
            if (t_valid >= 0 && !a_busy) break;
        end
        a_enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (t_valid - t_rden !== 2 || t_rden < 0) begin errors++; $display("FAIL single_latency got %0d expected 2", t_valid - t_rden); end
        checks++; if (a_rden_cnt - rc0 !== 1) begin errors++; $display("FAIL single_rden_pulses got %0d expected 1", a_rden_cnt - rc0); end
        checks++; if (a_bytes.size() !== 4) begin errors++; $display("FAIL single_byte_count got %0d expected 4", a_bytes.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < a_bytes.size()) ? a_bytes[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d got %h expected %h", i, got, exp_b[i]); end
        end
        checks++; if (t_last_acc - t_first_acc !== 3 || t_first_acc < 0) begin errors++; $display("FAIL single_back_to_back got %0d expected 3", t_last_acc - t_first_acc); end
        checks++; if (a_words !== 16'h0001) begin errors++; $display("FAIL single_words got %h expected 0001", a_words); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b expected 0", a_busy); end
    endtask

    task automatic test_stall();
        logic [7:0] exp_b[4];
        logic [7:0] got;
        logic [7:0] p_data = 8'h00;
        logic       p_valid = 1'b0, p_ready = 1'b0, seen_valid = 1'b0, finished = 1'b0;
        int         unstable = 0;
        exp_b = '{8'hA5, 8'hAB, 8'hCD, 8'hEF};
        @(negedge clk);
        a_bytes.delete();
        a_fifo.push_back(24'hABCDEF);
        a_enable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (p_valid && !p_ready && (a_tx_data !== p_data || a_tx_valid !== 1'b1)) unstable++;
            if (a_tx_valid) seen_valid = 1'b1;
            if (seen_valid && !a_busy) begin finished = 1'b1; break; end
            p_data     = a_tx_data;
            p_valid    = a_tx_valid;
            a_tx_ready = (i % 4 == 0) || (i % 4 == 3);
            p_ready    = a_tx_ready;
        end
        a_enable   = 1'b0;
        a_tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL stall_timeout got %b expected 1", finished); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_hold got %0d changes expected 0", unstable); end
        checks++; if (a_bytes.size() !== 4) begin errors++; $display("FAIL stall_byte_count got %0d expected 4", a_bytes.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < a_bytes.size()) ? a_bytes[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL stall_byte%0d got %h expected %h", i, got, exp_b[i]); end
        end
        checks++; if (a_words !== 16'h0002) begin errors++; $display("FAIL stall_words got %h expected 0002", a_words); end
    endtask

    task automatic test_enable_drop();
        logic [7:0] exp_b[4];
        logic [7:0] got;
        int rc0;
        exp_b = '{8'hA5, 8'h11, 8'h11, 8'h11};
        @(negedge clk);
        a_bytes.delete();
        rc0 = a_rden_cnt;
        a_fifo.push_back(24'h111111);
        a_fifo.push_back(24'h222222);
        a_fifo.push_back(24'h333333);
        a_tx_ready = 1'b1;
        a_enable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_bytes.size() >= 2) break;
        end
        a_enable = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (a_rden_cnt - rc0 !== 1) begin errors++; $display("FAIL endrop_rden_pulses got %0d expected 1", a_rden_cnt - rc0); end
        checks++; if (a_bytes.size() !== 4) begin errors++; $display("FAIL endrop_byte_count got %0d expected 4", a_bytes.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < a_bytes.size()) ? a_bytes[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL endrop_byte%0d got %h expected %h", i, got, exp_b[i]); end
        end
        checks++; if (a_words !== 16'h0003) begin errors++; $display("FAIL endrop_words got %h expected 0003", a_words); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b expected 0", a_busy); end
        checks++; if (a_fifo.size() !== 2) begin errors++; $display("FAIL endrop_fifo_left got %0d expected 2", a_fifo.size()); end
    endtask

    task automatic test_reset_mid_send();
        logic [7:0] exp_b[4];
        logic [7:0] got;
        logic       seen_valid = 1'b0;
        exp_b = '{8'hA5, 8'h78, 8'h9A, 8'hBC};
        @(negedge clk);
        a_fifo.delete();
        a_fifo.push_back(24'h123456);
        a_fifo.push_back(24'h789ABC);
        a_bytes.delete();
        a_tx_ready = 1'b1;
        a_enable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_bytes.size() >= 2) break;
        end
        checks++; if (a_tx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_send got %b expected 1", a_tx_valid); end
        a_rst_n = 1'b0;
        #1;
        checks++; if ({a_rden, a_tx_valid, a_busy} !== 3'b000) begin errors++; $display("FAIL rstmid_async_flags got %b expected 000", {a_rden, a_tx_valid, a_busy}); end
        checks++; if (a_tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_async_data got %h expected 00", a_tx_data); end
        checks++; if (a_words !== 16'h0000) begin errors++; $display("FAIL rstmid_async_words got %h expected 0000", a_words); end
        @(negedge clk);
        a_bytes.delete();
        a_rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_tx_valid) seen_valid = 1'b1;
            if (seen_valid && !a_busy) break;
        end
        a_enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_bytes.size() !== 4) begin errors++; $display("FAIL rstmid_byte_count got %0d expected 4", a_bytes.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < a_bytes.size()) ? a_bytes[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h expected %h", i, got, exp_b[i]); end
        end
        checks++; if (a_words !== 16'h0001) begin errors++; $display("FAIL rstmid_words got %h expected 0001", a_words); end
        checks++; if (a_bad_rd !== 0) begin errors++; $display("FAIL a_read_when_empty got %0d expected 0", a_bad_rd); end
    endtask

    task automatic test_wrap_noheader_lat2();
        logic [7:0] exp_b[3];
        logic [7:0] got;
        int t_rden = -1, t_valid = -1;
        exp_b = '{8'h12, 8'h34, 8'h56};
        @(negedge clk);
        b_bytes.delete();
        b_fifo.push_back(24'h123456);
        b_tx_ready = 1'b1;
        b_enable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_rden && t_rden < 0) t_rden = i;
            if (b_tx_valid && t_valid < 0) t_valid = i;
            if (t_valid >= 0 && !b_busy) break;
        end
        b_enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (t_valid - t_rden !== 3 || t_rden < 0) begin errors++; $display("FAIL lat2_latency got %0d expected 3", t_valid - t_rden); end
        checks++; if (b_rden_cnt !== 1) begin errors++; $display("FAIL lat2_rden_pulses got %0d expected 1", b_rden_cnt); end
        checks++; if (b_bytes.size() !== 3) begin errors++; $display("FAIL lat2_byte_count got %0d expected 3", b_bytes.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < b_bytes.size()) ? b_bytes[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL lat2_byte%0d got %h expected %h", i, got, exp_b[i]); end
        end
        checks++; if (b_words !== 16'h0000) begin errors++; $display("FAIL wrap_words got %h expected 0000", b_words); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL lat2_busy_after got %b expected 0", b_busy); end
        checks++; if (b_bad_rd !== 0) begin errors++; $display("FAIL b_read_when_empty got %0d expected 0", b_bad_rd); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_word();
        test_stall();
        test_enable_drop();
        test_reset_mid_send();
        test_wrap_noheader_lat2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
